// File: rtl/pipe_controller_if.sv
// Signal bundle between the pipelined ARM control unit and its datapath.
// The controller takes the slave modport. The datapath, or a bench standing
// in for it, takes the master modport.
//
// Timing contract: there is no valid/ready handshake on this bundle.
// - Inputs are sampled at the rising edge of clk.
// - D-stage outputs are combinational on InstrD.
// - E/M/W-stage outputs come straight from pipeline registers.
// - FlagsDbg exposes the architectural NZCV register for observation.
interface pipe_controller_if;
  logic [19:0] InstrD;
  logic [3:0]  ALUFlags;
  logic        FlushE;
  logic [1:0]  RegSrcD;
  logic [1:0]  ImmSrcD;
  logic        ALUSrcE;
  logic [1:0]  ALUControlE;
  logic        BranchTakenE;
  logic        MemtoRegE;
  logic        MemWriteM;
  logic        RegWriteM;
  logic        RegWriteW;
  logic        MemtoRegW;
  logic        PCSrcW;
  logic        PCWrPendingF;
  logic [3:0]  FlagsDbg;

  modport master (
    output InstrD, ALUFlags, FlushE,
    input  RegSrcD, ImmSrcD, ALUSrcE, ALUControlE, BranchTakenE, MemtoRegE,
    input  MemWriteM, RegWriteM, RegWriteW, MemtoRegW, PCSrcW, PCWrPendingF,
    input  FlagsDbg
  );

  modport slave (
    input  InstrD, ALUFlags, FlushE,
    output RegSrcD, ImmSrcD, ALUSrcE, ALUControlE, BranchTakenE, MemtoRegE,
    output MemWriteM, RegWriteM, RegWriteW, MemtoRegW, PCSrcW, PCWrPendingF,
    output FlagsDbg
  );
endinterface

// File: rtl/pipe_controller.sv
// Pipelined control unit for a 5-stage ARM datapath.
// - Decodes InstrD into control bits.
// - Carries those bits through the D->E, E->M and M->W registers.
// - Evaluates the condition field in Execute against a registered NZCV.
module pipe_controller (
  input  logic          clk,
  input  logic          reset,
  pipe_controller_if.slave bus
);

  typedef struct packed {
    logic       reg_w;
    logic       mem_w;
    logic       mem_to_reg;
    logic       alu_src;
    logic [1:0] alu_ctrl;
    logic [1:0] flag_w;
    logic       branch;
    logic       pcs;
    logic [3:0] cond;
  } de_ctrl_t;

  // InstrD holds instruction bits [31:12], so bit k of the instruction is InstrD[k-12].
  logic [3:0] cond_d;
  logic [1:0] op_d;
  logic [5:0] funct_d;
  logic [3:0] rd_d;
  logic       unused_rn;

  assign cond_d    = bus.InstrD[19:16];
  assign op_d      = bus.InstrD[15:14];
  assign funct_d   = bus.InstrD[13:8];
  assign rd_d      = bus.InstrD[3:0];
  assign unused_rn = ^bus.InstrD[7:4];

  de_ctrl_t   dec;
  logic       is_addsub;
  logic [1:0] reg_src_d;
  logic [1:0] imm_src_d;

  // Main decoder and ALU decoder for the decode-stage instruction.
  always_comb begin
    dec       = '0;
    is_addsub = 1'b0;
    reg_src_d = 2'b00;
    imm_src_d = 2'b00;
    case (op_d)
      2'b00: begin
        dec.alu_src = funct_d[5];
        dec.reg_w   = 1'b1;
        case (funct_d[4:1])
          4'b0100: begin dec.alu_ctrl = 2'b00; is_addsub = 1'b1; end
          4'b0010: begin dec.alu_ctrl = 2'b01; is_addsub = 1'b1; end
          4'b0000: dec.alu_ctrl = 2'b10;
          4'b1100: dec.alu_ctrl = 2'b11;
          default: begin dec.alu_ctrl = 2'b00; dec.reg_w = 1'b0; end
        endcase
        dec.flag_w[1] = funct_d[0];
        dec.flag_w[0] = funct_d[0] & is_addsub;
      end
      2'b01: begin
        dec.alu_src    = 1'b1;
        imm_src_d      = 2'b01;
        dec.alu_ctrl   = funct_d[3] ? 2'b00 : 2'b01;
        dec.reg_w      = funct_d[0];
        dec.mem_w      = ~funct_d[0];
        dec.mem_to_reg = funct_d[0];
        reg_src_d      = funct_d[0] ? 2'b00 : 2'b10;
      end
      2'b10: begin
        dec.branch   = 1'b1;
        dec.alu_src  = 1'b1;
        imm_src_d    = 2'b10;
        reg_src_d    = 2'b01;
        dec.alu_ctrl = 2'b00;
      end
      default: ;
    endcase
    dec.pcs  = ((rd_d == 4'hF) & dec.reg_w) | dec.branch;
    dec.cond = cond_d;
  end

  // Pipeline state registers
  de_ctrl_t   de_d, de_q;
  logic [3:0] flags_d, flags_q;
  logic       reg_write_m_d, reg_write_m_q;
  logic       mem_write_m_d, mem_write_m_q;
  logic       mem_to_reg_m_d, mem_to_reg_m_q;
  logic       pc_src_m_d, pc_src_m_q;
  logic       reg_write_w_d, reg_write_w_q;
  logic       mem_to_reg_w_d, mem_to_reg_w_q;
  logic       pc_src_w_d, pc_src_w_q;

  // D->E capture. A flush loads a bubble with every enable and Cond cleared.
  always_comb begin
    de_d = bus.FlushE ? '0 : dec;
  end

  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_ex_e;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  // Condition check of the Execute instruction against the registered flags.
  always_comb begin
    cond_ex_e = 1'b0;
    case (de_q.cond)
      4'b0000: cond_ex_e = flag_z;
      4'b0001: cond_ex_e = ~flag_z;
      4'b0010: cond_ex_e = flag_c;
      4'b0011: cond_ex_e = ~flag_c;
      4'b0100: cond_ex_e = flag_n;
      4'b0101: cond_ex_e = ~flag_n;
      4'b0110: cond_ex_e = flag_v;
      4'b0111: cond_ex_e = ~flag_v;
      4'b1000: cond_ex_e = flag_c & ~flag_z;
      4'b1001: cond_ex_e = ~flag_c | flag_z;
      4'b1010: cond_ex_e = (flag_n == flag_v);
      4'b1011: cond_ex_e = (flag_n != flag_v);
      4'b1100: cond_ex_e = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex_e = flag_z | (flag_n != flag_v);
      4'b1110: cond_ex_e = 1'b1;
      default: cond_ex_e = 1'b0;
    endcase
  end

  // Condition-gated Execute results feeding the flags register and E->M / M->W.
  always_comb begin
    flags_d = flags_q;
    if (de_q.flag_w[1] & cond_ex_e) flags_d[3:2] = bus.ALUFlags[3:2];
    if (de_q.flag_w[0] & cond_ex_e) flags_d[1:0] = bus.ALUFlags[1:0];
    reg_write_m_d  = de_q.reg_w & cond_ex_e;
    mem_write_m_d  = de_q.mem_w & cond_ex_e;
    pc_src_m_d     = de_q.pcs & cond_ex_e;
    mem_to_reg_m_d = de_q.mem_to_reg;
    reg_write_w_d  = reg_write_m_q;
    mem_to_reg_w_d = mem_to_reg_m_q;
    pc_src_w_d     = pc_src_m_q;
  end

  // All pipeline state and the flags register clear asynchronously on reset low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      de_q           <= '0;
      flags_q        <= '0;
      reg_write_m_q  <= 1'b0;
      mem_write_m_q  <= 1'b0;
      mem_to_reg_m_q <= 1'b0;
      pc_src_m_q     <= 1'b0;
      reg_write_w_q  <= 1'b0;
      mem_to_reg_w_q <= 1'b0;
      pc_src_w_q     <= 1'b0;
    end else begin
      de_q           <= de_d;
      flags_q        <= flags_d;
      reg_write_m_q  <= reg_write_m_d;
      mem_write_m_q  <= mem_write_m_d;
      mem_to_reg_m_q <= mem_to_reg_m_d;
      pc_src_m_q     <= pc_src_m_d;
      reg_write_w_q  <= reg_write_w_d;
      mem_to_reg_w_q <= mem_to_reg_w_d;
      pc_src_w_q     <= pc_src_w_d;
    end
  end

  assign bus.RegSrcD      = reg_src_d;
  assign bus.ImmSrcD      = imm_src_d;
  assign bus.ALUSrcE      = de_q.alu_src;
  assign bus.ALUControlE  = de_q.alu_ctrl;
  assign bus.BranchTakenE = de_q.branch & cond_ex_e;
  assign bus.MemtoRegE    = de_q.mem_to_reg;
  assign bus.MemWriteM    = mem_write_m_q;
  assign bus.RegWriteM    = reg_write_m_q;
  assign bus.RegWriteW    = reg_write_w_q;
  assign bus.MemtoRegW    = mem_to_reg_w_q;
  assign bus.PCSrcW       = pc_src_w_q;
  assign bus.PCWrPendingF = dec.pcs | (de_q.pcs & cond_ex_e) | pc_src_m_q;
  assign bus.FlagsDbg     = flags_q;

endmodule

// File: tb/tb_pipe_controller.sv
// Directed bench for pipe_controller.
// Instructions are driven #1 after each rising edge and outputs are checked
// before the next edge. Expected values are hand-computed constants.
module tb_pipe_controller;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  pipe_controller_if bus ();

  pipe_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Encode instruction bits [31:12] = {Cond, Op, Funct, Rn=0, Rd}.
  function automatic logic [19:0] mk(input logic [3:0] c, input logic [1:0] op,
                                     input logic [5:0] f, input logic [3:0] rd);
    return {c, op, f, 4'h0, rd};
  endfunction

  localparam logic [19:0] NOP      = 20'hF0000;   // cond NV, AND r0: never executes
  localparam logic [19:0] ADDS_R1  = 20'hE0901;   // ADDS r1
  localparam logic [19:0] SUBS_R2  = 20'hE0502;   // SUBS r2
  localparam logic [19:0] BEQ      = 20'h08000;   // BEQ
  localparam logic [19:0] ADDNES   = 20'h10903;   // ADDNES r3
  localparam logic [19:0] STR_DOWN = 20'hE5004;   // STR r4, U=0
  localparam logic [19:0] LDR_UP   = 20'hE5905;   // LDR r5, U=1
  localparam logic [19:0] ADD_PC   = 20'hE080F;   // ADD pc
  localparam logic [19:0] ADDS_PC  = 20'hE090F;   // ADDS pc

  task automatic check_eq(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Flags preset, branch cond, expected BranchTakenE
  logic [3:0] tf [8] = '{4'b0010, 4'b0110, 4'b1000, 4'b1001, 4'b1001, 4'b0100, 4'b0000, 4'b0000};
  logic [3:0] tc [8] = '{4'h8,    4'h8,    4'hB,    4'hA,    4'hC,    4'hD,    4'hF,    4'hE};
  logic       te [8] = '{1'b1,    1'b0,    1'b1,    1'b1,    1'b1,    1'b1,    1'b0,    1'b1};

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b0;
    bus.InstrD = NOP;
    bus.ALUFlags = 4'h0;
    bus.FlushE = 1'b0;
    tick();
    tick();
    check_eq("rst_regwm", bus.RegWriteM, 1'b0);
    check_eq("rst_regww", bus.RegWriteW, 1'b0);
    check_eq("rst_memwm", bus.MemWriteM, 1'b0);
    check_eq("rst_pcsw", bus.PCSrcW, 1'b0);
    check_eq("rst_flags", bus.FlagsDbg, 4'h0);
    reset = 1'b1;
    tick();

    // ADDS: flags captured from ALUFlags, write-back at n+3
    bus.InstrD = ADDS_R1;
    #1 check_eq("adds_regsrc", bus.RegSrcD, 2'b00);
    check_eq("adds_pcpend", bus.PCWrPendingF, 1'b0);
    tick();
    bus.InstrD = NOP;
    bus.ALUFlags = 4'b0110;
    #1 check_eq("adds_aluctl", bus.ALUControlE, 2'b00);
    check_eq("adds_alusrc", bus.ALUSrcE, 1'b0);
    tick();
    bus.ALUFlags = 4'h0;
    check_eq("adds_flags", bus.FlagsDbg, 4'b0110);
    check_eq("adds_regwm", bus.RegWriteM, 1'b1);
    tick();
    check_eq("adds_regww", bus.RegWriteW, 1'b1);
    check_eq("adds_m2rw", bus.MemtoRegW, 1'b0);

    // SUBS then BEQ, first with Z set, then with Z clear
    for (int k = 0; k < 2; k++) begin
      bus.InstrD = SUBS_R2;
      tick();
      bus.ALUFlags = (k == 0) ? 4'b0100 : 4'b0000;
      bus.InstrD = BEQ;
      #1 check_eq("beq_pcpend_d", bus.PCWrPendingF, 1'b1);
      tick();
      bus.ALUFlags = 4'h0;
      bus.InstrD = NOP;
      #1 check_eq("beq_taken", bus.BranchTakenE, (k == 0) ? 1'b1 : 1'b0);
      check_eq("beq_alusrc", bus.ALUSrcE, 1'b1);
      tick();
    end

    // ADDNES suppressed by Z=1: no write, flags untouched
    bus.InstrD = SUBS_R2;
    tick();
    bus.ALUFlags = 4'b0100;
    bus.InstrD = ADDNES;
    tick();
    bus.ALUFlags = 4'b0000;
    bus.InstrD = NOP;
    #1 check_eq("ne_aluctl", bus.ALUControlE, 2'b00);
    tick();
    check_eq("ne_regwm", bus.RegWriteM, 1'b0);
    check_eq("ne_flags", bus.FlagsDbg, 4'b0100);
    tick();
    check_eq("ne_regww", bus.RegWriteW, 1'b0);

    // STR with U=0
    bus.InstrD = STR_DOWN;
    #1 check_eq("str_regsrc", bus.RegSrcD, 2'b10);
    check_eq("str_immsrc", bus.ImmSrcD, 2'b01);
    tick();
    bus.InstrD = LDR_UP;
    #1 check_eq("str_aluctl", bus.ALUControlE, 2'b01);
    check_eq("str_m2re", bus.MemtoRegE, 1'b0);
    check_eq("ldr_regsrc", bus.RegSrcD, 2'b00);
    tick();
    bus.InstrD = NOP;
    check_eq("str_memwm", bus.MemWriteM, 1'b1);
    check_eq("str_regwm", bus.RegWriteM, 1'b0);
    check_eq("ldr_m2re", bus.MemtoRegE, 1'b1);
    check_eq("ldr_aluctl", bus.ALUControlE, 2'b00);
    tick();
    check_eq("str_regww", bus.RegWriteW, 1'b0);
    check_eq("ldr_regwm", bus.RegWriteM, 1'b1);
    check_eq("ldr_memwm", bus.MemWriteM, 1'b0);
    tick();
    check_eq("ldr_regww", bus.RegWriteW, 1'b1);
    check_eq("ldr_m2rw", bus.MemtoRegW, 1'b1);

    // ADD to PC: pending through D, E, M; PCSrcW at n+3
    bus.InstrD = ADD_PC;
    #1 check_eq("pc_pend_d", bus.PCWrPendingF, 1'b1);
    tick();
    bus.InstrD = NOP;
    #1 check_eq("pc_pend_e", bus.PCWrPendingF, 1'b1);
    tick();
    check_eq("pc_pend_m", bus.PCWrPendingF, 1'b1);
    tick();
    check_eq("pc_pcsw", bus.PCSrcW, 1'b1);
    check_eq("pc_regww", bus.RegWriteW, 1'b1);
    check_eq("pc_pend_w", bus.PCWrPendingF, 1'b0);

    // Same instruction (flag-setting) flushed at its D->E edge
    bus.InstrD = ADDS_PC;
    bus.FlushE = 1'b1;
    tick();
    bus.FlushE = 1'b0;
    bus.InstrD = NOP;
    bus.ALUFlags = 4'b1111;
    #1 check_eq("fl_pend_e", bus.PCWrPendingF, 1'b0);
    tick();
    bus.ALUFlags = 4'h0;
    check_eq("fl_flags", bus.FlagsDbg, 4'b0100);
    check_eq("fl_regwm", bus.RegWriteM, 1'b0);
    tick();
    check_eq("fl_regww", bus.RegWriteW, 1'b0);
    check_eq("fl_pcsw", bus.PCSrcW, 1'b0);

    // Condition table: preset flags via ADDS, then a branch with each condition
    for (int i = 0; i < 8; i++) begin
      bus.InstrD = ADDS_R1;
      tick();
      bus.ALUFlags = tf[i];
      bus.InstrD = mk(tc[i], 2'b10, 6'h00, 4'h0);
      tick();
      bus.ALUFlags = 4'h0;
      bus.InstrD = NOP;
      #1 check_eq($sformatf("cond_%0d_flags", i), bus.FlagsDbg, tf[i]);
      check_eq($sformatf("cond_%0d_taken", i), bus.BranchTakenE, te[i]);
      tick();
    end

    // Asynchronous reset mid-stream with LDR in M and flags nonzero
    bus.InstrD = ADDS_R1;
    tick();
    bus.ALUFlags = 4'b1010;
    bus.InstrD = LDR_UP;
    tick();
    bus.ALUFlags = 4'h0;
    bus.InstrD = NOP;
    tick();
    check_eq("pre_rst_regwm", bus.RegWriteM, 1'b1);
    check_eq("pre_rst_flags", bus.FlagsDbg, 4'b1010);
    #2 reset = 1'b0;
    #1 check_eq("arst_regwm", bus.RegWriteM, 1'b0);
    check_eq("arst_m2rw", bus.MemtoRegW, 1'b0);
    check_eq("arst_flags", bus.FlagsDbg, 4'h0);
    bus.InstrD = STR_DOWN;
    #1 check_eq("arst_regsrc_d", bus.RegSrcD, 2'b10);
    tick();
    reset = 1'b1;
    bus.InstrD = NOP;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_eq("post_regwm", bus.RegWriteM, 1'b0);
      check_eq("post_regww", bus.RegWriteW, 1'b0);
      check_eq("post_memwm", bus.MemWriteM, 1'b0);
      check_eq("post_m2re", bus.MemtoRegE, 1'b0);
      check_eq("post_m2rw", bus.MemtoRegW, 1'b0);
      check_eq("post_pcsw", bus.PCSrcW, 1'b0);
      check_eq("post_flags", bus.FlagsDbg, 4'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_controller.md
Name: pipe_controller

Overview:
Pipelined control unit for the 5-stage ARM datapath. It decodes the decode-stage instruction fields, carries control bits through D→E→M→W pipeline registers, and evaluates the condition field in Execute against a registered NZCV flags register. It drives the datapath's per-stage control inputs and exports the stage-tagged signals the hazard unit needs.

Parameters:
NONE, -, fixed 32-bit ARM subset (DP ADD/SUB/AND/ORR, LDR/STR, B).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; reset=0 clears all state
InstrD  in  20  decode-stage instruction bits [31:12]: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12]
ALUFlags  in  4  execute-stage ALU flags {N,Z,C,V}
FlushE  in  1  synchronous bubble insert into D→E register
RegSrcD  out  2  decode mux selects, combinational
ImmSrcD  out  2  extend select, combinational
ALUSrcE  out  1  SrcB select, execute
ALUControlE  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
BranchTakenE  out  1  conditioned branch in execute
MemtoRegE  out  1  load in execute (load-use detect)
MemWriteM  out  1  data memory write enable
RegWriteM  out  1  for forwarding
RegWriteW  out  1  register file write enable
MemtoRegW  out  1  result mux select
PCSrcW  out  1  writeback writes PC
PCWrPendingF  out  1  PCS in D, E or M

Behaviour:
- Decode (combinational on InstrD):
  - Op=00 (DP): cmd=Funct[4:1]. ADD 0100→00, SUB 0010→01, AND 0000→10, ORR 1100→11; any other cmd→ALUControl 00, RegW 0.
  - Op=00: ALUSrc=Funct[5]; RegW=1; ImmSrc=00; RegSrc=00.
  - Op=00 with S=Funct[0]: FlagW[1] (NZ) = S; FlagW[0] (CV) = S & (ADD|SUB).
  - Op=01 (mem): ALUSrc=1; ImmSrc=01; ALUControl = Funct[3] ? 00 : 01 (U bit).
  - Op=01 with L=Funct[0]: RegW=L, MemW=~L, MemtoReg=L; RegSrc=10 when store, else 00.
  - Op=10 (B): Branch=1; ALUSrc=1; ImmSrc=10; RegSrc=01; ALUControl=00; no writes.
  - Op=11: undefined, all write/branch/flag enables 0.
  - PCS = (Rd==1111 & RegW) | Branch.
- D→E register: RegW, MemW, MemtoReg, ALUSrc, ALUControl, FlagW, Branch, PCS, Cond.
  - FlushE=1 at the edge loads all enables and Cond=0000 (bubble).
  - FlushE does not affect E→M or M→W.
- Execute condition logic, CondExE from Cond and registered Flags:
  - EQ 0000 Z; NE 0001 ~Z; CS 0010 C; CC 0011 ~C; MI 0100 N; PL 0101 ~N; VS 0110 V; VC 0111 ~V.
  - HI 1000 C&~Z; LS 1001 ~C|Z; GE 1010 N==V; LT 1011 N!=V; GT 1100 ~Z&(N==V); LE 1101 Z|(N!=V).
  - AL 1110 1; 1111 0.
- Gating: RegWrite, MemWrite, PCS, FlagW and Branch are ANDed with CondExE before use or pipelining. BranchTakenE=BranchE&CondExE. MemtoRegE is ungated.
- Flags register:
  - Flags[3:2] ← ALUFlags[3:2] at the edge when FlagWE[1]&CondExE; Flags[1:0] likewise with FlagWE[0].
  - A flag-setting instruction in E is evaluated against the old flags. The following instruction sees the new flags.
- E→M register: gated RegWrite, MemWrite, PCSrc, plus MemtoReg. M→W register: RegWrite, MemtoReg, PCSrc.
- Latency: an instruction presented on InstrD in cycle n is in E in cycle n+1, M in n+2 and W in n+3.
- PCWrPendingF = PCSD | PCSE | PCSrcM, where PCSD is ungated and PCSE is gated.
- Reset: asynchronous, any cycle including mid-instruction.
  - All pipeline registers and Flags go to 0, so all E/M/W outputs are 0 during and after reset until new instructions arrive.
  - D-stage outputs follow InstrD.

Test Plan:
- Reset: reset=0 mid-stream with LDR in M → RegWriteM=0, MemtoRegW=0, Flags=0000 immediately; after release, NOP stream → all E/M/W outputs stay 0.
- ADDS: ADDS (cond 1110, Funct 001001) producing ALUFlags=0110 in E → Flags=0110 next cycle; ALUControlE=00; RegWriteW=1 at n+3.
- Conditional branch: SUBS with ALUFlags=0100 followed by BEQ → BranchTakenE=1 for BEQ; same sequence with ALUFlags=0000 → BranchTakenE=0.
- Suppression: ADDNE with Z=1 → RegWriteM=0, RegWriteW=0, Flags unchanged even with S=1.
- Memory: STR (U=0) → RegSrcD=10, ImmSrcD=01, ALUControlE=01, MemWriteM=1, RegWriteW=0. LDR → MemtoRegE=1, then RegWriteW=1 and MemtoRegW=1 at n+3.
- PC write and flush:
  - ADD with Rd=15 → PCWrPendingF=1 for cycles n..n+2 and PCSrcW=1 at n+3.
  - Same instruction with FlushE=1 at its D→E edge → no RegWriteW or PCSrcW, and Flags unchanged.
